nibble_serial_add_ctrl: RTL and testbench

Sequencing controller that performs WORD_W-bit add/subtract by time-sharing one 4-bit ripple-carry adder slice. The slice is built from the team's fa/ha cells and instantiated inside this block. Each cycle the controller feeds one nibble of the latched operands to the slice, registers the nibble sum, and recirculates the carry into the next nibble. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.

---
 rtl/nibble_serial_add_ctrl.sv | 165 ++++++++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_add_ctrl.sv
// Word add/subtract sequenced through one 4-bit ripple slice,
// one nibble per cycle, with valid/ready on operand and result sides.

module ha (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;
endmodule

module fa (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  logic w_s0, w_c0, w_c1;

  ha u_ha0 (.i_a(i_a),  .i_b(i_b), .o_s(w_s0), .o_c(w_c0));
  ha u_ha1 (.i_a(w_s0), .i_b(i_c), .o_s(o_s),  .o_c(w_c1));

  assign o_c = w_c0 | w_c1;
endmodule

module nibble_serial_add_ctrl #(
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [WORD_W-1:0] op_a,
  input  logic [WORD_W-1:0] op_b,
  input  logic              cin,
  input  logic              sub,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [WORD_W-1:0] sum,
  output logic              cout,
  output logic              ovf,
  output logic              busy,
  output logic [((WORD_W/4) > 1 ? $clog2(WORD_W/4) : 1)-1:0] nib_idx
);
  localparam int NUM_NIB = WORD_W / 4;
  localparam int IDX_W   = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;
  localparam int MSB     = WORD_W - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state, w_next;

  logic [WORD_W-1:0] r_a, r_b, r_sum;
  logic              r_c, r_cout, r_ovf, r_res_valid, r_busy;
  logic [IDX_W-1:0]  r_idx;

  logic [3:0] w_an, w_bn, w_s;
  logic [4:0] w_c;
  logic       w_last;

  // Operand nibble select driven by the current nibble index
  always_comb begin
    w_an = '0;
    w_bn = '0;
    for (int k = 0; k < NUM_NIB; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_an = r_a[4*k +: 4];
        w_bn = r_b[4*k +: 4];
      end
    end
  end

  assign w_c[0] = r_c;

  for (genvar g = 0; g < 4; g++) begin : g_slice
    fa u_fa (
      .i_a(w_an[g]),
      .i_b(w_bn[g]),
      .i_c(w_c[g]),
      .o_s(w_s[g]),
      .o_c(w_c[g+1])
    );
  end

  assign w_last = (r_idx == IDX_W'(NUM_NIB - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start_valid) w_next = RUN;
      RUN:     if (w_last)      w_next = DONE;
      DONE:    if (res_ready)   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_c         <= 1'b0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_idx       <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start_valid) begin
            r_a    <= op_a;
            r_b    <= sub ? ~op_b : op_b;
            r_c    <= sub | cin;
            r_idx  <= '0;
            r_busy <= 1'b1;
          end
        end
        RUN: begin
          for (int k = 0; k < NUM_NIB; k++) begin
            if (r_idx == IDX_W'(k)) r_sum[4*k +: 4] <= w_s;
          end
          r_c <= w_c[4];
          if (w_last) begin
            r_cout      <= w_c[4];
            // Overflow uses the MSB nibble result, not the old sum
            r_ovf       <= (r_a[MSB] == r_b[MSB]) && (w_s[3] != r_a[MSB]);
            r_res_valid <= 1'b1;
            r_idx       <= '0;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        DONE: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign start_ready = (r_state == IDLE);
  assign res_valid   = r_res_valid;
  assign sum         = r_sum;
  assign cout        = r_cout;
  assign ovf         = r_ovf;
  assign busy        = r_busy;
  assign nib_idx     = r_idx;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed plus random bench for nibble_serial_add_ctrl with an
// expected-result queue filled at accept and drained at res_valid.

module tb_nibble_serial_add_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        start_valid, start_ready;
  logic [15:0] op_a, op_b;
  logic        cin, sub;
  logic        res_valid, res_ready;
  logic [15:0] sum;
  logic        cout, ovf, busy;
  logic [1:0]  nib_idx;

  typedef struct {
    logic [15:0] s;
    logic        co;
    logic        ov;
  } exp_t;

  exp_t q[$];
  int   vecs = 0;
  int   errs = 0;

  nibble_serial_add_ctrl #(.WORD_W(16)) dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready),
    .op_a(op_a), .op_b(op_b), .cin(cin), .sub(sub),
    .res_valid(res_valid), .res_ready(res_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy),
    .nib_idx(nib_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic ci, input logic sb);
    exp_t        e;
    logic [15:0] bb;
    logic [16:0] t;
    bb   = sb ? ~b : b;
    t    = {1'b0, a} + {1'b0, bb} + {16'd0, (sb ? 1'b1 : ci)};
    e.s  = t[15:0];
    e.co = t[16];
    e.ov = (a[15] == bb[15]) && (t[15] != a[15]);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept an operation, check RUN sequencing, stop once res_valid is up
  task automatic launch(input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic sb, input exp_t e);
    chk("start_ready_pre", start_ready, 1);
    op_a = a; op_b = b; cin = ci; sub = sb;
    start_valid = 1'b1;
    q.push_back(e);
    tick();
    start_valid = 1'b0;
    op_a = $urandom; op_b = $urandom; cin = $urandom; sub = $urandom;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("nib_idx_%0d", i), nib_idx, i);
      chk($sformatf("busy_run_%0d", i), busy, 1);
      chk($sformatf("rv_low_%0d", i), res_valid, 0);
      chk($sformatf("sr_low_%0d", i), start_ready, 0);
      tick();
    end
    chk("res_valid_lat4", res_valid, 1);
  endtask

  task automatic collect();
    exp_t e;
    if (q.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
    end else begin
      e = q.pop_front();
      chk("sum", sum, e.s);
      chk("cout", cout, e.co);
      chk("ovf", ovf, e.ov);
    end
  endtask

  task automatic release_res();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("rv_after_ack", res_valid, 0);
    chk("busy_after_ack", busy, 0);
    chk("sr_after_ack", start_ready, 1);
  endtask

  task automatic op(input logic [15:0] a, input logic [15:0] b,
                    input logic ci, input logic sb, input exp_t e);
    launch(a, b, ci, sb, e);
    collect();
    release_res();
  endtask

  function automatic exp_t mk(input logic [15:0] s, input logic co,
                              input logic ov);
    exp_t e;
    e.s = s; e.co = co; e.ov = ov;
    return e;
  endfunction

  initial begin
    logic [15:0] ra, rb;
    logic        rc, rs;
    rst = 1'b1;
    start_valid = 1'b0; res_ready = 1'b0;
    op_a = '0; op_b = '0; cin = 1'b0; sub = 1'b0;
    #12;
    chk("rst_sum", sum, 0);
    chk("rst_rv", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_idx", nib_idx, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;
    tick();
    chk("sr_after_rst", start_ready, 1);

    op(16'h1234, 16'h0FCD, 1'b0, 1'b0, mk(16'h2201, 1'b0, 1'b0));
    op(16'hFFFF, 16'h0001, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b0));
    op(16'h000F, 16'h0000, 1'b1, 1'b0, mk(16'h0010, 1'b0, 1'b0));
    op(16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(16'h8000, 1'b0, 1'b1));
    op(16'h0005, 16'h0007, 1'b0, 1'b1, mk(16'hFFFE, 1'b0, 1'b0));
    op(16'h0005, 16'h0007, 1'b1, 1'b1, mk(16'hFFFE, 1'b0, 1'b0));
    op(16'h8000, 16'h0001, 1'b0, 1'b1, mk(16'h7FFF, 1'b1, 1'b1));
    op(16'h8000, 16'h0001, 1'b1, 1'b1, mk(16'h7FFF, 1'b1, 1'b1));

    // Backpressure: stuck in DONE while new requests are offered
    launch(16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(16'h8000, 1'b0, 1'b1));
    for (int i = 0; i < 5; i++) begin
      start_valid = 1'b1;
      op_a = $urandom; op_b = $urandom; cin = $urandom; sub = $urandom;
      tick();
      chk("bp_rv", res_valid, 1);
      chk("bp_sum", sum, 16'h8000);
      chk("bp_cout", cout, 0);
      chk("bp_ovf", ovf, 1);
      chk("bp_sr", start_ready, 0);
      chk("bp_busy", busy, 1);
    end
    start_valid = 1'b0;
    collect();
    release_res();
    op(16'h1234, 16'h0FCD, 1'b0, 1'b0, mk(16'h2201, 1'b0, 1'b0));

    // Asynchronous reset between the second and third RUN edges
    op_a = 16'h1234; op_b = 16'h0FCD; cin = 1'b0; sub = 1'b0;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    tick();
    tick();
    chk("pre_rst_idx", nib_idx, 2);
    #2 rst = 1'b1;
    #1;
    chk("arst_sum", sum, 0);
    chk("arst_rv", res_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_idx", nib_idx, 0);
    #1 rst = 1'b0;
    tick();
    chk("sr_post_arst", start_ready, 1);
    op(16'hFFFF, 16'h0001, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b0));

    for (int i = 0; i < 6; i++) begin
      ra = $urandom; rb = $urandom; rc = $urandom; rs = $urandom;
      op(ra, rb, rc, rs, model(ra, rb, rc, rs));
    end

    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
